// File: rtl/fmps_pkg.sv
// Shared FMPS definitions: status codes, header layout and parser state encodings.
package fmps_pkg;

    typedef enum logic [1:0] {
        ST_SUCCESS    = 2'd0,
        ST_BAD_HEADER = 2'd1,
        ST_BAD_SIZE   = 2'd2,
        ST_DUPLICATE  = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        S_HEADER = 2'd0,
        S_DATA   = 2'd1,
        S_DRAIN  = 2'd2
    } parser_state_t;

    localparam logic [1:0] FMPS_TYPE      = 2'b11;
    localparam int         HDR_TYPE_HI    = 31;
    localparam int         HDR_TYPE_LO    = 30;
    localparam int         HDR_ENABLE_BIT = 29;

    function automatic logic headerTypeOk(input logic [31:0] word);
        return word[HDR_TYPE_HI:HDR_TYPE_LO] == FMPS_TYPE;
    endfunction

endpackage

// File: rtl/fmps_link_dpram.sv
// Simple dual-port node-data store: one write port, one registered read port (old data on collision).
module fmps_link_dpram #(
    parameter int INDEX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wrEnable,
    input  logic [INDEX_WIDTH-1:0] wrAddress,
    input  logic [31:0]            wrData,
    input  logic [INDEX_WIDTH-1:0] rdAddress,
    output logic [31:0]            rdData
);

    logic [31:0] mem [0:(1<<INDEX_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wrEnable) begin
            mem[wrAddress] <= wrData;
        end
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdData <= '0;
        end else begin
            rdData <= mem[rdAddress];
        end
    end

endmodule

// File: rtl/fmps_link_receiver.sv
// Per-link FMPS packet receiver: parses two-beat packets, stores node data and tracks
// which nodes arrived in the current FA cycle.
module fmps_link_receiver
    import fmps_pkg::*;
#(
    parameter int INDEX_WIDTH = 5,
    parameter     dbg         = "false"
) (
    input  logic                       auClk,
    input  logic                       auReset,
    input  logic                       FAstrobe,
    input  logic                       allFMPSpresent,
    input  logic                       TVALID,
    input  logic                       TLAST,
    input  logic [31:0]                TDATA,
    output logic                       statusStrobe,
    output logic [1:0]                 statusCode,
    output logic                       statusFMPSenabled,
    output logic [INDEX_WIDTH-1:0]     statusFMPSindex,
    output logic [INDEX_WIDTH:0]       fmpsCounter,
    output logic [(1<<INDEX_WIDTH)-1:0] fmpsBitmap,
    input  logic [INDEX_WIDTH-1:0]     readoutAddress,
    output logic [31:0]                readoutFMPS
);

    localparam int FMPS_COUNT_WIDTH = INDEX_WIDTH + 1;
    localparam int NODES            = 1 << INDEX_WIDTH;

    (* mark_debug = dbg *) parser_state_t    state;
    logic [INDEX_WIDTH-1:0]                  hdrIndex;
    logic                                    hdrEnabled;

    logic [NODES-1:0]            bitmapBase;
    logic [FMPS_COUNT_WIDTH-1:0] counterBase;
    logic [INDEX_WIDTH-1:0]      beatIndex;
    logic                        beatEnabled;
    logic                        dataEnd;
    logic                        isDuplicate;
    logic                        storeBeat;

    // An FA strobe clears tracking before any packet landing in the same cycle is applied.
    always_comb begin
        bitmapBase  = FAstrobe ? '0 : fmpsBitmap;
        counterBase = FAstrobe ? '0 : fmpsCounter;
        beatIndex   = TDATA[INDEX_WIDTH-1:0];
        beatEnabled = TDATA[HDR_ENABLE_BIT];
        dataEnd     = TVALID && (state == S_DATA) && TLAST;
        isDuplicate = bitmapBase[hdrIndex];
        storeBeat   = dataEnd && !isDuplicate && !allFMPSpresent;
    end

    always_ff @(posedge auClk) begin
        if (auReset) begin
            state             <= S_HEADER;
            hdrIndex          <= '0;
            hdrEnabled        <= 1'b0;
            statusStrobe      <= 1'b0;
            statusCode        <= ST_SUCCESS;
            statusFMPSindex   <= '0;
            statusFMPSenabled <= 1'b0;
            fmpsBitmap        <= '0;
            fmpsCounter       <= '0;
        end else begin
            statusStrobe <= 1'b0;
            fmpsBitmap   <= bitmapBase;
            fmpsCounter  <= counterBase;
            if (storeBeat) begin
                fmpsBitmap  <= bitmapBase | (NODES'(1) << hdrIndex);
                fmpsCounter <= counterBase + FMPS_COUNT_WIDTH'(1);
            end
            if (TVALID) begin
                case (state)
                    S_HEADER: begin
                        if (TLAST || !headerTypeOk(TDATA)) begin
                            statusStrobe      <= 1'b1;
                            statusCode        <= TLAST ? ST_BAD_SIZE : ST_BAD_HEADER;
                            statusFMPSindex   <= beatIndex;
                            statusFMPSenabled <= beatEnabled;
                            state             <= TLAST ? S_HEADER : S_DRAIN;
                        end else begin
                            hdrIndex   <= beatIndex;
                            hdrEnabled <= beatEnabled;
                            state      <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        statusStrobe      <= 1'b1;
                        statusFMPSindex   <= hdrIndex;
                        statusFMPSenabled <= hdrEnabled;
                        if (TLAST) begin
                            statusCode <= isDuplicate ? ST_DUPLICATE : ST_SUCCESS;
                            state      <= S_HEADER;
                        end else begin
                            statusCode <= ST_BAD_SIZE;
                            state      <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (TLAST) begin
                            state <= S_HEADER;
                        end
                    end
                    default: state <= S_HEADER;
                endcase
            end
        end
    end

    fmps_link_dpram #(
        .INDEX_WIDTH(INDEX_WIDTH)
    ) dpram (
        .clk       (auClk),
        .rst       (auReset),
        .wrEnable  (storeBeat && !auReset),
        .wrAddress (hdrIndex),
        .wrData    (TDATA),
        .rdAddress (readoutAddress),
        .rdData    (readoutFMPS)
    );

endmodule

// File: tb/tb_fmps_link_receiver.sv
// Scoreboard bench for fmps_link_receiver with a packet-level reference model.
module tb_fmps_link_receiver;

    localparam int IW    = 5;
    localparam int NODES = 1 << IW;
    localparam int FCW   = IW + 1;

    logic              auClk;
    logic              auReset;
    logic              FAstrobe;
    logic              allFMPSpresent;
    logic              TVALID;
    logic              TLAST;
    logic [31:0]       TDATA;
    logic              statusStrobe;
    logic [1:0]        statusCode;
    logic              statusFMPSenabled;
    logic [IW-1:0]     statusFMPSindex;
    logic [FCW-1:0]    fmpsCounter;
    logic [NODES-1:0]  fmpsBitmap;
    logic [IW-1:0]     readoutAddress;
    logic [31:0]       readoutFMPS;

    fmps_link_receiver #(.INDEX_WIDTH(IW)) dut (
        .auClk             (auClk),
        .auReset           (auReset),
        .FAstrobe          (FAstrobe),
        .allFMPSpresent    (allFMPSpresent),
        .TVALID            (TVALID),
        .TLAST             (TLAST),
        .TDATA             (TDATA),
        .statusStrobe      (statusStrobe),
        .statusCode        (statusCode),
        .statusFMPSenabled (statusFMPSenabled),
        .statusFMPSindex   (statusFMPSindex),
        .fmpsCounter       (fmpsCounter),
        .fmpsBitmap        (fmpsBitmap),
        .readoutAddress    (readoutAddress),
        .readoutFMPS       (readoutFMPS)
    );

    initial auClk = 1'b0;
    always #5 auClk = ~auClk;

    typedef struct {
        logic [1:0]       code;
        logic [IW-1:0]    idx;
        logic             en;
        logic [NODES-1:0] bm;
        logic [FCW-1:0]   cnt;
    } exp_t;

    exp_t             expQ[$];
    exp_t             monExp;
    int               checks   = 0;
    int               failures = 0;
    logic [NODES-1:0] mBitmap  = '0;
    logic [31:0]      mMem [NODES];
    bit               mMemValid [NODES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every status strobe must match the oldest expected packet outcome.
    always @(negedge auClk) begin
        if (!auReset && statusStrobe) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual=code%0d/idx%0d required=no_strobe",
                         statusCode, statusFMPSindex);
            end else begin
                monExp = expQ.pop_front();
                check("status_code",    32'(statusCode),        32'(monExp.code));
                check("status_index",   32'(statusFMPSindex),   32'(monExp.idx));
                check("status_enabled", 32'(statusFMPSenabled), 32'(monExp.en));
                check("status_bitmap",  32'(fmpsBitmap),        32'(monExp.bm));
                check("status_counter", 32'(fmpsCounter),       32'(monExp.cnt));
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            TVALID   = 1'b0;
            TDATA    = $urandom;
            TLAST    = 1'($urandom_range(0, 1));
            FAstrobe = 1'b0;
            @(posedge auClk); #1;
        end
    endtask

    task automatic idleFA();
        TVALID   = 1'b0;
        FAstrobe = 1'b1;
        mBitmap  = '0;
        @(posedge auClk); #1;
        FAstrobe = 1'b0;
    endtask

    // Packet-level model: outcome decided from length, header type and node history.
    task automatic sendPkt(input int len, input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [31:0] b3,
                           input bit fa, input bit afp, input bit gaps);
        logic [31:0] beats [4];
        exp_t        e;
        bit          goodType;
        bit          decideOnLast;
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        goodType     = (b0[31:30] == 2'b11);
        decideOnLast = (len == 1) || (goodType && len == 2);
        if (fa && decideOnLast) mBitmap = '0;
        e.idx = b0[IW-1:0];
        e.en  = b0[29];
        if (len == 1)       e.code = 2'd2;
        else if (!goodType) e.code = 2'd1;
        else if (len == 2) begin
            if (mBitmap[e.idx]) e.code = 2'd3;
            else begin
                e.code = 2'd0;
                if (!afp) begin
                    mBitmap[e.idx]   = 1'b1;
                    mMem[e.idx]      = b1;
                    mMemValid[e.idx] = 1'b1;
                end
            end
        end else            e.code = 2'd2;
        e.bm  = mBitmap;
        e.cnt = FCW'($countones(mBitmap));
        expQ.push_back(e);
        if (fa && !decideOnLast) mBitmap = '0;

        allFMPSpresent = afp;
        for (int i = 0; i < len; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            TVALID   = 1'b1;
            TDATA    = beats[i];
            TLAST    = (i == len - 1);
            FAstrobe = fa && (i == len - 1);
            @(posedge auClk); #1;
        end
        TVALID         = 1'b0;
        FAstrobe       = 1'b0;
        allFMPSpresent = 1'b0;
    endtask

    task automatic settle();
        idle(2);
        check("queue_empty", 32'(expQ.size()), 32'd0);
    endtask

    task automatic readCheck(input logic [IW-1:0] a);
        readoutAddress = a;
        @(posedge auClk); #1;
        if (mMemValid[a]) check("readout", readoutFMPS, mMem[a]);
    endtask

    task automatic checkResetState();
        check("rst_strobe",  32'(statusStrobe),      32'd0);
        check("rst_code",    32'(statusCode),        32'd0);
        check("rst_index",   32'(statusFMPSindex),   32'd0);
        check("rst_enabled", 32'(statusFMPSenabled), 32'd0);
        check("rst_bitmap",  32'(fmpsBitmap),        32'd0);
        check("rst_counter", 32'(fmpsCounter),       32'd0);
        check("rst_readout", readoutFMPS,            32'd0);
    endtask

    initial begin
        #2_000_000;
        checks++;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        auReset = 1'b1; FAstrobe = 1'b0; allFMPSpresent = 1'b0;
        TVALID = 1'b0; TLAST = 1'b0; TDATA = '0; readoutAddress = '0;
        repeat (3) @(posedge auClk);
        #1;
        checkResetState();
        auReset = 1'b0;
        idle(1);

        // Basic store, duplicate, bad header, bad size
        sendPkt(2, 32'hC000_0005, 32'h1234_5678, 0, 0, 0, 0, 0);
        settle();
        check("t1_bitmap", 32'(fmpsBitmap), 32'h20);
        check("t1_counter", 32'(fmpsCounter), 32'd1);
        readCheck(5);
        check("t1_readout", readoutFMPS, 32'h1234_5678);
        sendPkt(2, 32'hC000_0005, 32'h0000_DEAD, 0, 0, 0, 0, 0);
        settle();
        readCheck(5);
        check("t2_readout", readoutFMPS, 32'h1234_5678);
        check("t2_counter", 32'(fmpsCounter), 32'd1);
        sendPkt(3, 32'h4000_0003, 32'h1, 32'h2, 0, 0, 0, 0);
        sendPkt(2, 32'hC000_0003, 32'hABCD_0003, 0, 0, 0, 0, 0);
        settle();
        sendPkt(1, 32'hC000_0002, 0, 0, 0, 0, 0, 0);
        sendPkt(3, 32'hC000_0004, 32'h44, 32'h45, 0, 0, 0, 0);
        settle();
        check("t4_bitmap", 32'(fmpsBitmap), 32'h28);

        // FA cycle handling and frozen readout
        idleFA();
        sendPkt(2, 32'hC000_0009, 32'h9999_0000, 0, 0, 0, 0, 0);
        idleFA();
        sendPkt(2, 32'hC000_0000, 32'h0000_0A00, 0, 0, 0, 0, 0);
        sendPkt(2, 32'hE000_0005, 32'h0000_0A05, 0, 0, 0, 0, 0);
        settle();
        check("t5_bitmap_pre", 32'(fmpsBitmap), 32'h21);
        sendPkt(2, 32'hC000_0007, 32'h0000_0A07, 0, 0, 1, 0, 0);
        settle();
        check("t5_bitmap_fa", 32'(fmpsBitmap), 32'h80);
        check("t5_counter_fa", 32'(fmpsCounter), 32'd1);
        sendPkt(2, 32'hC000_0009, 32'h1111_2222, 0, 0, 0, 1, 0);
        settle();
        readCheck(9);
        check("t5_readout_frozen", readoutFMPS, 32'h9999_0000);

        // Randomised traffic
        for (int p = 0; p < 300; p++) begin
            int          r;
            int          len;
            logic [31:0] hdr;
            r   = $urandom_range(0, 9);
            len = (r == 0) ? 1 : (r <= 7) ? 2 : (r == 8) ? 3 : 4;
            hdr = $urandom;
            if ($urandom_range(0, 9) < 8) hdr[31:30] = 2'b11;
            readoutAddress = IW'($urandom);
            sendPkt(len, hdr, $urandom, $urandom, $urandom,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 1);
            if ($urandom_range(0, 19) == 0) idleFA();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        settle();
        for (int a = 0; a < NODES; a++) readCheck(IW'(a));

        // Reset in the middle of a packet
        TVALID = 1'b1; TDATA = 32'hC000_0006; TLAST = 1'b0;
        @(posedge auClk); #1;
        TVALID  = 1'b0;
        auReset = 1'b1;
        readoutAddress = '0;
        @(posedge auClk); #1;
        checkResetState();
        mBitmap = '0;
        auReset = 1'b0;
        sendPkt(2, 32'h0000_0001, 32'h0000_0055, 0, 0, 0, 0, 0);
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
